bcd_counter_mux: RTL and testbench
==================================

Name: bcd_counter_mux

Overview:
- Multi-digit BCD event counter with a programmable prescaler, up/down counting, parallel load and display multiplexing.
- Generalises the single-digit 0–9 seconds counter to NUM_DIGITS cascaded decimal digits.
- Sits between the board clock and the seg7 decoder.
- digit_bcd feeds seg7; digit_sel drives the common anodes/cathodes.

Parameters:
- NUM_DIGITS, 4: number of cascaded BCD digits; legal range 1–8.
- PRESCALE_WIDTH, 24: prescaler counter width.
- DEFAULT_COMPARE, 24'd10_000_000: effective compare value used when compare_in == 0.
- MUX_DIV_WIDTH, 10: refresh divider width; each digit is shown for 2^MUX_DIV_WIDTH cycles.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- compare_in  input  PRESCALE_WIDTH  prescaler compare; 0 selects DEFAULT_COMPARE
- count_en  input  1  1 = prescaler runs; 0 = prescaler and digits hold
- up_down  input  1  1 = count up, 0 = count down; sampled on each step
- load  input  1  synchronous parallel load strobe
- load_value  input  4*NUM_DIGITS  BCD load data; digit 0 in [3:0]
- bcd_value  output  4*NUM_DIGITS  current count, digit 0 least significant
- tick  output  1  one-cycle pulse per counter step
- rollover  output  1  one-cycle pulse on full-range wrap
- digit_sel  output  NUM_DIGITS  one-hot active-high digit enable
- digit_bcd  output  4  nibble of the currently selected digit
- prescale_count  output  PRESCALE_WIDTH  live prescaler value (debug/GPIO)

Behaviour:
- Interface: single clock clk; reset is synchronous and active-high. All state updates on posedge clk.
- Reset values: prescale_count=0, bcd_value=0, tick=0, rollover=0, refresh counter=0, digit index=0, digit_sel=1 (digit 0). Reset has top priority, including mid-count and mid-load.
- Effective compare eff = (compare_in==0) ? DEFAULT_COMPARE : compare_in.
- Priority per edge: reset > load > count.
- Load:
  - bcd_value <= load_value, with any nibble >9 replaced by 0.
  - prescale_count <= 0; tick=0, rollover=0 that cycle.
  - Refresh/mux logic is unaffected.
- Count, when count_en=1 and no load:
  - If prescale_count >= eff: prescale_count <= 0 and the counter steps once. So the step period is eff+1 cycles.
  - Otherwise prescale_count increments by 1.
  - The >= test means lowering compare_in below the current count wraps on the next enabled cycle, with no 2^PRESCALE_WIDTH run-out.
- count_en=0: prescaler and bcd_value hold; tick and rollover are 0.
- Step up: digit 0 increments; a digit at 9 becomes 0 and carries into the next digit. All-9s becomes all-0s and asserts rollover.
- Step down: a digit at 0 becomes 9 and borrows from the next digit. All-0s becomes all-9s and asserts rollover.
- tick and rollover are registered:
  - High for exactly the one cycle in which the new bcd_value is first visible.
  - rollover implies tick.
- Only the up_down value sampled on the stepping edge matters; toggling it between steps is legal.
- Display multiplexing:
  - The refresh counter is free-running and independent of count_en and load.
  - On refresh-counter wrap, the digit index advances 0→1→…→NUM_DIGITS-1→0.
  - digit_sel = one-hot(index).
  - digit_bcd = bcd_value nibble at index. It is combinational from registers, so it has zero latency with respect to bcd_value.
- NUM_DIGITS=1: digit_sel is constantly 1.
- All arithmetic is unsigned. No internal value may leave the range 0–9 per nibble.

Test Plan:
- NUM_DIGITS=2, compare_in=3, up_down=1, count_en=1 after reset: tick every 4 cycles; bcd_value 0x00→0x01→…→0x09→0x10 (carry on 10th step); tick coincides with each new value.
- Load 0x98, then count up with compare_in=3: 0x99, then 0x00 with rollover=1 and tick=1 in the same cycle; rollover=0 on all other steps.
- Load 0x01, up_down=0: steps give 0x00, then 0x99 with rollover=1; 0x99→0x98 with rollover=0.
- compare_in=100, wait until prescale_count=50, then set compare_in=10: prescale_count goes to 0 and tick fires on the next cycle. compare_in=0 with DEFAULT_COMPARE=5: period is 6 cycles.
- count_en=0 for 20 cycles mid-period: prescale_count and bcd_value frozen and tick=0. Load 0xAF: bcd_value=0x00. Load and reset asserted together: reset wins.
- MUX_DIV_WIDTH=2, NUM_DIGITS=4, bcd_value=0x1234: digit_sel cycles 0001→0010→0100→1000 every 4 cycles with digit_bcd 4,3,2,1; the cycle continues unchanged while count_en=0.

Source files
------------

// File: rtl/bcd_counter_mux.sv
// Multi-digit BCD event counter: programmable prescaler, up/down stepping, parallel load,
// and a free-running display multiplexer that drives a seg7 decoder and digit enables.
module bcd_counter_mux #(
    parameter int unsigned                NUM_DIGITS      = 4,
    parameter int unsigned                PRESCALE_WIDTH  = 24,
    parameter logic [PRESCALE_WIDTH-1:0]  DEFAULT_COMPARE = 24'd10_000_000,
    parameter int unsigned                MUX_DIV_WIDTH   = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PRESCALE_WIDTH-1:0] compare_in,
    input  logic                      count_en,
    input  logic                      up_down,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   load_value,
    output logic [4*NUM_DIGITS-1:0]   bcd_value,
    output logic                      tick,
    output logic                      rollover,
    output logic [NUM_DIGITS-1:0]     digit_sel,
    output logic [3:0]                digit_bcd,
    output logic [PRESCALE_WIDTH-1:0] prescale_count
);

    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BcdW = 4 * NUM_DIGITS;

    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [BcdW-1:0]           bcd_q, bcd_d;
    logic                      tick_q, tick_d;
    logic                      rollover_q, rollover_d;
    logic [MUX_DIV_WIDTH-1:0]  refresh_q;
    logic [IdxW-1:0]           idx_q;

    logic [PRESCALE_WIDTH-1:0] eff_compare;
    logic [BcdW-1:0]           stepped;
    logic [BcdW-1:0]           loaded;
    logic                      wrap;
    logic [3:0]                nib;

    assign eff_compare = (compare_in == '0) ? DEFAULT_COMPARE : compare_in;

    // Ripple carry/borrow through the digits; surviving carry means full-range wrap.
    always_comb begin
        stepped = bcd_q;
        wrap    = 1'b1;
        nib     = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib = bcd_q[4*i +: 4];
            if (wrap) begin
                if (up_down) begin
                    if (nib >= 4'd9) begin
                        stepped[4*i +: 4] = 4'd0;
                    end else begin
                        stepped[4*i +: 4] = nib + 4'd1;
                        wrap = 1'b0;
                    end
                end else begin
                    if (nib == 4'd0) begin
                        stepped[4*i +: 4] = 4'd9;
                    end else begin
                        stepped[4*i +: 4] = nib - 4'd1;
                        wrap = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        loaded = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            loaded[4*i +: 4] = (load_value[4*i +: 4] > 4'd9) ? 4'd0 : load_value[4*i +: 4];
        end
    end

    always_comb begin
        prescale_d = prescale_q;
        bcd_d      = bcd_q;
        tick_d     = 1'b0;
        rollover_d = 1'b0;
        if (load) begin
            bcd_d      = loaded;
            prescale_d = '0;
        end else if (count_en) begin
            // >= rather than == so a lowered compare wraps immediately.
            if (prescale_q >= eff_compare) begin
                prescale_d = '0;
                bcd_d      = stepped;
                tick_d     = 1'b1;
                rollover_d = wrap;
            end else begin
                prescale_d = prescale_q + PRESCALE_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_q <= '0;
            bcd_q      <= '0;
            tick_q     <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            bcd_q      <= bcd_d;
            tick_q     <= tick_d;
            rollover_q <= rollover_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_q <= '0;
            idx_q     <= '0;
        end else begin
            refresh_q <= refresh_q + MUX_DIV_WIDTH'(1);
            if (&refresh_q) begin
                idx_q <= (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
            end
        end
    end

    always_comb begin
        digit_bcd = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IdxW'(i)) begin
                digit_bcd = bcd_q[4*i +: 4];
            end
        end
    end

    assign digit_sel      = NUM_DIGITS'(1) << idx_q;
    assign bcd_value      = bcd_q;
    assign tick           = tick_q;
    assign rollover       = rollover_q;
    assign prescale_count = prescale_q;

endmodule

// File: tb/tb_bcd_counter_mux.sv
// Bench for bcd_counter_mux: directed scenarios then random stimulus, every cycle compared
// against an integer-valued reference model of the counter, prescaler and refresh schedule.
module tb_bcd_counter_mux;

    localparam int ND = 4;
    localparam int PW = 8;
    localparam int DefCmp = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic [PW-1:0]   compare_in;
    logic            count_en;
    logic            up_down;
    logic            load;
    logic [4*ND-1:0] load_value;
    logic [4*ND-1:0] bcd_value;
    logic            tick;
    logic            rollover;
    logic [ND-1:0]   digit_sel;
    logic [3:0]      digit_bcd;
    logic [PW-1:0]   prescale_count;

    int passed = 0;
    int total  = 0;

    // Model state: count as a plain integer 0..9999, prescaler, refresh edges since reset.
    int m_val, m_pcnt, m_ref;
    bit m_tick, m_roll;

    bcd_counter_mux #(
        .NUM_DIGITS      (ND),
        .PRESCALE_WIDTH  (PW),
        .DEFAULT_COMPARE (8'd5),
        .MUX_DIV_WIDTH   (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .compare_in     (compare_in),
        .count_en       (count_en),
        .up_down        (up_down),
        .load           (load),
        .load_value     (load_value),
        .bcd_value      (bcd_value),
        .tick           (tick),
        .rollover       (rollover),
        .digit_sel      (digit_sel),
        .digit_bcd      (digit_bcd),
        .prescale_count (prescale_count)
    );

    always #5 clk = ~clk;

    function automatic int pow10(int e);
        int r = 1;
        for (int k = 0; k < e; k++) r = r * 10;
        return r;
    endfunction

    function automatic int bcd_to_int(logic [4*ND-1:0] v);
        int s = 0;
        int d;
        for (int k = 0; k < ND; k++) begin
            d = int'(v[4*k +: 4]);
            if (d > 9) d = 0;
            s = s + d * pow10(k);
        end
        return s;
    endfunction

    function automatic logic [4*ND-1:0] int_to_bcd(int v);
        logic [4*ND-1:0] r = '0;
        for (int k = 0; k < ND; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_edge();
        int modn, eff;
        modn = pow10(ND);
        if (reset) begin
            m_val = 0; m_pcnt = 0; m_ref = 0; m_tick = 0; m_roll = 0;
        end else begin
            m_ref++;
            m_tick = 0;
            m_roll = 0;
            if (load) begin
                m_val  = bcd_to_int(load_value);
                m_pcnt = 0;
            end else if (count_en) begin
                eff = (compare_in == 0) ? DefCmp : int'(compare_in);
                if (m_pcnt >= eff) begin
                    m_pcnt = 0;
                    m_tick = 1;
                    if (up_down) begin
                        m_roll = (m_val == modn - 1);
                        m_val  = (m_val + 1) % modn;
                    end else begin
                        m_roll = (m_val == 0);
                        m_val  = (m_val + modn - 1) % modn;
                    end
                end else begin
                    m_pcnt++;
                end
            end
        end
    endtask

    task automatic check_all();
        int idx;
        idx = (m_ref / 4) % ND;
        chk("bcd_value", 32'(bcd_value), 32'(int_to_bcd(m_val)));
        chk("prescale_count", 32'(prescale_count), 32'(m_pcnt));
        chk("tick", 32'(tick), 32'(m_tick));
        chk("rollover", 32'(rollover), 32'(m_roll));
        chk("digit_sel", 32'(digit_sel), 32'(1) << idx);
        chk("digit_bcd", 32'(digit_bcd), 32'((m_val / pow10(idx)) % 10));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    initial begin
        reset = 1'b1; compare_in = 8'd3; count_en = 1'b0; up_down = 1'b1;
        load = 1'b0; load_value = '0;
        run(2);
        reset = 1'b0;

        // Up count with period 4, through the first decimal carry.
        count_en = 1'b1;
        run(4 * 12);

        // Up through full-range wrap.
        load = 1'b1; load_value = 16'h9998; cyc(); load = 1'b0;
        run(4 * 3);

        // Down through zero.
        load = 1'b1; load_value = 16'h0001; cyc(); load = 1'b0;
        up_down = 1'b0;
        run(4 * 4);

        // Lowering compare below the live prescaler value wraps on the next cycle.
        up_down = 1'b1; compare_in = 8'd100;
        for (int k = 0; k < 120; k++) begin
            if (m_pcnt == 50) break;
            cyc();
        end
        chk("pcnt_reached_50", 32'(prescale_count), 32'd50);
        compare_in = 8'd10;
        cyc();
        chk("lowered_cmp_tick", 32'(tick), 32'd1);
        chk("lowered_cmp_pcnt", 32'(prescale_count), 32'd0);
        compare_in = 8'd0;
        run(20);

        // Hold, sanitised load, reset beating load.
        compare_in = 8'd3;
        run(2);
        count_en = 1'b0;
        run(20);
        count_en = 1'b1;
        run(5);
        load = 1'b1; load_value = 16'h00AF; cyc(); load = 1'b0;
        chk("load_sanitize", 32'(bcd_value), 32'd0);
        run(3);
        load = 1'b1; reset = 1'b1; load_value = 16'h5555; cyc();
        load = 1'b0; reset = 1'b0;
        chk("reset_over_load", 32'(bcd_value), 32'd0);

        // Display scan with the counter frozen.
        load = 1'b1; load_value = 16'h1234; cyc(); load = 1'b0;
        count_en = 1'b0;
        run(20);

        // Randomised phase.
        for (int k = 0; k < 800; k++) begin
            reset      = ($urandom_range(0, 199) == 0);
            load       = ($urandom_range(0, 39) == 0);
            load_value = 16'($urandom);
            count_en   = ($urandom_range(0, 9) != 0);
            up_down    = 1'($urandom);
            if ($urandom_range(0, 29) == 0) compare_in = 8'($urandom_range(0, 6));
            cyc();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
